// File: rtl/nice_icb_arbiter_if.sv
// nice_icb_arbiter_if: one ICB link carrying a command channel and its response channel
interface nice_icb_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_read;
    logic [DW-1:0] cmd_wdata;
    logic [DW/8-1:0] cmd_wmask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/nice_icb_arbiter.sv
// nice_icb_arbiter: round-robin two-requester ICB arbiter with command lock and in-order response routing
module nice_icb_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int OUTS_DEPTH = 4
) (
    input  logic              nice_clk,
    input  logic              nice_rst_n,
    nice_icb_arbiter_if.slave  s0_icb,
    nice_icb_arbiter_if.slave  s1_icb,
    nice_icb_arbiter_if.master m_icb,
    output logic              busy,
    output logic              spurious_rsp
);
    localparam int PW = $clog2(OUTS_DEPTH);
    logic [PW:0]           cnt;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [OUTS_DEPTH-1:0] id_q;
    logic                  rr_ptr, lock, lock_id;
    logic                  grant, fifo_full, fifo_empty, head, push, pop;
    logic [AW-1:0]         addr_mux;
    logic [DW-1:0]         wdata_mux;
    logic [DW/8-1:0]       wmask_mux;

    assign fifo_full  = cnt == (PW+1)'(OUTS_DEPTH);
    assign fifo_empty = cnt == '0;
    // a stalled command keeps its grant until accepted
    assign grant = lock ? lock_id : (s0_icb.cmd_valid & s1_icb.cmd_valid) ? rr_ptr : s1_icb.cmd_valid;
    assign head  = id_q[rd_ptr];

    assign addr_mux            = grant ? s1_icb.cmd_addr  : s0_icb.cmd_addr;
    assign wdata_mux           = grant ? s1_icb.cmd_wdata : s0_icb.cmd_wdata;
    assign wmask_mux           = grant ? s1_icb.cmd_wmask : s0_icb.cmd_wmask;
    assign m_icb.cmd_addr      = addr_mux;
    assign m_icb.cmd_wdata     = wdata_mux;
    assign m_icb.cmd_wmask     = wmask_mux;
    assign m_icb.cmd_read      = grant ? s1_icb.cmd_read : s0_icb.cmd_read;
    assign m_icb.cmd_valid     = (grant ? s1_icb.cmd_valid : s0_icb.cmd_valid) & ~fifo_full;
    assign s0_icb.cmd_ready    = ~grant & m_icb.cmd_ready & ~fifo_full;
    assign s1_icb.cmd_ready    = grant & m_icb.cmd_ready & ~fifo_full;
    assign push                = m_icb.cmd_valid & m_icb.cmd_ready;

    assign m_icb.rsp_ready     = fifo_empty | (head ? s1_icb.rsp_ready : s0_icb.rsp_ready);
    assign pop                 = m_icb.rsp_valid & m_icb.rsp_ready & ~fifo_empty;
    assign s0_icb.rsp_valid    = m_icb.rsp_valid & ~fifo_empty & ~head;
    assign s1_icb.rsp_valid    = m_icb.rsp_valid & ~fifo_empty & head;
    assign s0_icb.rsp_rdata    = m_icb.rsp_rdata;
    assign s1_icb.rsp_rdata    = m_icb.rsp_rdata;
    assign s0_icb.rsp_err      = m_icb.rsp_err;
    assign s1_icb.rsp_err      = m_icb.rsp_err;
    assign busy                = (cnt != '0) | s0_icb.cmd_valid | s1_icb.cmd_valid;

    always_ff @(posedge nice_clk or negedge nice_rst_n)
        if (!nice_rst_n) begin
            cnt          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            id_q         <= '0;
            rr_ptr       <= 1'b0;
            lock         <= 1'b0;
            lock_id      <= 1'b0;
            spurious_rsp <= 1'b0;
        end else begin
            if (push) begin
                id_q[wr_ptr] <= grant;
                wr_ptr       <= wr_ptr + PW'(1);
                rr_ptr       <= ~grant;
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            cnt          <= cnt + (PW+1)'(push) - (PW+1)'(pop);
            lock         <= m_icb.cmd_valid & ~m_icb.cmd_ready;
            lock_id      <= grant;
            spurious_rsp <= m_icb.rsp_valid & fifo_empty;
        end
endmodule

// File: tb/tb_nice_icb_arbiter.sv
// tb_nice_icb_arbiter: vector table, directed corner sequences and a queue-based random reference model
module tb_nice_icb_arbiter;
    localparam int DEPTH = 4;
    logic nice_clk = 1'b0;
    logic nice_rst_n = 1'b0;
    logic busy, spurious_rsp;
    always #5 nice_clk = ~nice_clk;

    nice_icb_arbiter_if #(.AW(32), .DW(32)) s0 ();
    nice_icb_arbiter_if #(.AW(32), .DW(32)) s1 ();
    nice_icb_arbiter_if #(.AW(32), .DW(32)) m ();

    nice_icb_arbiter #(.AW(32), .DW(32), .OUTS_DEPTH(DEPTH)) dut (
        .nice_clk(nice_clk), .nice_rst_n(nice_rst_n),
        .s0_icb(s0), .s1_icb(s1), .m_icb(m),
        .busy(busy), .spurious_rsp(spurious_rsp)
    );

    typedef struct packed {
        logic s0v, s1v, mrdy, rspv, g;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [13];
    logic [31:0] il_rd [3];

    int n_vec = 0, n_err = 0;
    int mq[$];
    bit mdl_en = 0, rr_m, lk_m, lkid_m, sp_m, pend0, pend1;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge nice_clk);
        #1;
    endtask

    task automatic idle();
        s0.cmd_valid = 0; s1.cmd_valid = 0; m.cmd_ready = 0;
        m.rsp_valid = 0; m.rsp_err = 0; s0.rsp_ready = 1; s1.rsp_ready = 1;
    endtask

    task automatic do_reset();
        idle();
        nice_rst_n = 0;
        tick();
        nice_rst_n = 1;
    endtask

    // Reference: outstanding ids as a queue, priority as "whoever did not win last"
    always @(negedge nice_clk) if (mdl_en) begin
        bit g, full, empty, hd, mv, r0, r1, mrr;
        g     = lk_m ? lkid_m : (s0.cmd_valid && s1.cmd_valid) ? rr_m : s1.cmd_valid;
        full  = mq.size() == DEPTH;
        empty = mq.size() == 0;
        hd    = empty ? 1'b0 : (mq[0] != 0);
        mv    = (g ? s1.cmd_valid : s0.cmd_valid) && !full;
        r0    = !g && m.cmd_ready && !full;
        r1    = g && m.cmd_ready && !full;
        mrr   = empty || (hd ? s1.rsp_ready : s0.rsp_ready);
        chk("model_ctl",
            {m.cmd_valid, s0.cmd_ready, s1.cmd_ready, m.rsp_ready, s0.rsp_valid, s1.rsp_valid, busy, spurious_rsp},
            {mv, r0, r1, mrr, m.rsp_valid && !empty && !hd, m.rsp_valid && !empty && hd,
             mq.size() != 0 || s0.cmd_valid || s1.cmd_valid, sp_m});
        if (mv)
            chk("model_payload", {m.cmd_addr, m.cmd_read, m.cmd_wdata, m.cmd_wmask},
                g ? {s1.cmd_addr, s1.cmd_read, s1.cmd_wdata, s1.cmd_wmask}
                  : {s0.cmd_addr, s0.cmd_read, s0.cmd_wdata, s0.cmd_wmask});
        chk("model_rsp_data", {s0.rsp_rdata, s0.rsp_err, s1.rsp_rdata, s1.rsp_err},
            {m.rsp_rdata, m.rsp_err, m.rsp_rdata, m.rsp_err});
        sp_m = m.rsp_valid && empty;
        if (m.rsp_valid && mrr && !empty) void'(mq.pop_front());
        if (mv && m.cmd_ready) begin
            mq.push_back(int'(g));
            rr_m = !g;
        end
        lk_m   = mv && !m.cmd_ready;
        lkid_m = g;
        pend0  = s0.cmd_valid && !r0;
        pend1  = s1.cmd_valid && !r1;
    end

    initial begin
        tbl = '{
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'b1101_0010},
            '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'b1011_1010},
            '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'b1101_0110},
            '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'b1011_1010},
            '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'b1101_0110},
            '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'b1011_1010},
            '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'b1001_0110},
            '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'b1001_0010},
            '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'b1001_0010},
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'b1011_0010},
            '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'b1101_0110},
            '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'b0101_1010},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b0101_0000}
        };
        il_rd = '{32'h11, 32'h22, 32'h33};
        s0.cmd_addr = 0; s0.cmd_read = 0; s0.cmd_wdata = 0; s0.cmd_wmask = 0;
        s1.cmd_addr = 0; s1.cmd_read = 0; s1.cmd_wdata = 0; s1.cmd_wmask = 0;
        m.rsp_rdata = 0;
        idle();
        @(negedge nice_clk);
        chk("reset", {m.cmd_valid, m.rsp_ready, s0.rsp_valid, s1.rsp_valid, busy, spurious_rsp}, 6'b010000);
        tick();
        nice_rst_n = 1;

        // Round-robin alternation, grant lock while stalled, in-order routing
        do_reset();
        s0.cmd_addr = 32'h100; s1.cmd_addr = 32'h200;
        for (int i = 0; i < 13; i++) begin
            s0.cmd_valid = tbl[i].s0v; s1.cmd_valid = tbl[i].s1v;
            m.cmd_ready  = tbl[i].mrdy; m.rsp_valid = tbl[i].rspv;
            @(negedge nice_clk);
            chk($sformatf("tbl_row%0d", i),
                {m.cmd_valid, s0.cmd_ready, s1.cmd_ready, m.rsp_ready, s0.rsp_valid, s1.rsp_valid, busy, spurious_rsp},
                tbl[i].exp);
            if (tbl[i].exp[7])
                chk($sformatf("tbl_addr%0d", i), m.cmd_addr, tbl[i].g ? 32'h200 : 32'h100);
            tick();
        end

        // s0-only reads with responses one cycle behind
        do_reset();
        s0.cmd_read = 1; m.cmd_ready = 1;
        for (int k = 0; k < 4; k++) begin
            s0.cmd_valid = k < 3;
            s0.cmd_addr  = 32'h100 + 32'(4 * k);
            m.rsp_valid  = k > 0;
            m.rsp_rdata  = 32'hA0 + 32'(k) - 32'h1;
            @(negedge nice_clk);
            if (k < 3) chk("rd_cmd", {m.cmd_valid, s0.cmd_ready, s1.cmd_ready, m.cmd_addr}, {3'b110, 32'h100 + 32'(4 * k)});
            if (k > 0) chk("rd_rsp", {s0.rsp_valid, s1.rsp_valid, s0.rsp_rdata}, {2'b10, 32'hA0 + 32'(k) - 32'h1});
            tick();
        end
        idle();
        @(negedge nice_clk);
        chk("rd_idle", busy, 1'b0);
        tick();

        // Outstanding FIFO full: blocking, held response, pop does not free the same cycle
        do_reset();
        s0.cmd_valid = 1; s0.cmd_read = 0; m.cmd_ready = 1;
        for (int k = 0; k < 4; k++) begin
            s0.cmd_wdata = 32'(k);
            @(negedge nice_clk);
            chk("full_fill", {m.cmd_valid, s0.cmd_ready}, 2'b11);
            tick();
        end
        s0.cmd_wdata = 32'h55;
        @(negedge nice_clk);
        chk("full_block", {m.cmd_valid, s0.cmd_ready, busy}, 3'b001);
        tick();
        m.rsp_valid = 1; s0.rsp_ready = 0;
        @(negedge nice_clk);
        chk("full_rsp_hold", {m.rsp_ready, s0.rsp_valid, s0.cmd_ready}, 3'b010);
        tick();
        s0.rsp_ready = 1;
        @(negedge nice_clk);
        chk("full_rsp_pop", {m.rsp_ready, s0.rsp_valid, s0.cmd_ready, m.cmd_valid}, 4'b1100);
        tick();
        m.rsp_valid = 0;
        @(negedge nice_clk);
        chk("full_refill", {m.cmd_valid, s0.cmd_ready, m.cmd_wdata}, {2'b11, 32'h55});
        tick();

        // Interleaved issue s0,s1,s0 and response routing with error
        do_reset();
        m.cmd_ready = 1;
        s0.cmd_valid = 1; s0.cmd_addr = 32'h10;
        @(negedge nice_clk);
        chk("il_c0", {s0.cmd_ready, s1.cmd_ready, m.cmd_addr}, {2'b10, 32'h10});
        tick();
        s0.cmd_valid = 0; s1.cmd_valid = 1; s1.cmd_addr = 32'h20;
        @(negedge nice_clk);
        chk("il_c1", {s0.cmd_ready, s1.cmd_ready, m.cmd_addr}, {2'b01, 32'h20});
        tick();
        s1.cmd_valid = 0; s0.cmd_valid = 1; s0.cmd_addr = 32'h30;
        @(negedge nice_clk);
        chk("il_c2", {s0.cmd_ready, s1.cmd_ready, m.cmd_addr}, {2'b10, 32'h30});
        tick();
        s0.cmd_valid = 0;
        for (int k = 0; k < 3; k++) begin
            m.rsp_valid = 1; m.rsp_rdata = il_rd[k]; m.rsp_err = k == 1;
            @(negedge nice_clk);
            chk("il_rsp", {s0.rsp_valid, s1.rsp_valid, k == 1 ? s1.rsp_rdata : s0.rsp_rdata, k == 1 ? s1.rsp_err : s0.rsp_err},
                {k != 1, k == 1, il_rd[k], k == 1});
            tick();
        end

        // Spurious response on empty FIFO
        do_reset();
        m.rsp_valid = 1;
        @(negedge nice_clk);
        chk("spur_drain", {m.rsp_ready, s0.rsp_valid, s1.rsp_valid, spurious_rsp}, 4'b1000);
        tick();
        m.rsp_valid = 0;
        @(negedge nice_clk);
        chk("spur_pulse", spurious_rsp, 1'b1);
        tick();
        @(negedge nice_clk);
        chk("spur_end", spurious_rsp, 1'b0);
        tick();

        // Reset with two commands outstanding
        do_reset();
        m.cmd_ready = 1; s0.cmd_valid = 1;
        tick();
        tick();
        s0.cmd_valid = 0; m.cmd_ready = 0; m.rsp_valid = 1; s0.rsp_ready = 0;
        @(negedge nice_clk);
        chk("rst_pre", {s0.rsp_valid, busy}, 2'b11);
        nice_rst_n = 0;
        #1;
        chk("rst_mid", {busy, s0.rsp_valid, s1.rsp_valid, m.cmd_valid, m.rsp_ready}, 5'b00001);
        tick();
        nice_rst_n = 1;
        @(negedge nice_clk);
        chk("rst_after", {s0.rsp_valid, m.rsp_ready, spurious_rsp}, 3'b010);
        tick();
        @(negedge nice_clk);
        chk("rst_spur", spurious_rsp, 1'b1);
        tick();

        // Random traffic against the queue model; requesters hold pending commands
        do_reset();
        mq.delete();
        rr_m = 0; lk_m = 0; lkid_m = 0; sp_m = 0; pend0 = 0; pend1 = 0;
        mdl_en = 1;
        for (int c = 0; c < 3000; c++) begin
            if (!pend0) begin
                s0.cmd_valid = $urandom_range(0, 9) < 6;
                s0.cmd_addr  = $urandom;
                s0.cmd_read  = 1'($urandom_range(0, 1));
                s0.cmd_wdata = $urandom;
                s0.cmd_wmask = 4'($urandom_range(0, 15));
            end
            if (!pend1) begin
                s1.cmd_valid = $urandom_range(0, 9) < 6;
                s1.cmd_addr  = $urandom;
                s1.cmd_read  = 1'($urandom_range(0, 1));
                s1.cmd_wdata = $urandom;
                s1.cmd_wmask = 4'($urandom_range(0, 15));
            end
            m.cmd_ready  = $urandom_range(0, 9) < 6;
            m.rsp_valid  = $urandom_range(0, 9) < 5;
            m.rsp_rdata  = $urandom;
            m.rsp_err    = 1'($urandom_range(0, 1));
            s0.rsp_ready = $urandom_range(0, 9) < 7;
            s1.rsp_ready = $urandom_range(0, 9) < 7;
            tick();
        end
        mdl_en = 0;
        idle();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
